// File: rtl/piso_pkg.sv
// piso_pkg
// Shared types and sizing for the parallel-in serial-out serializer.
//   state_t        : serializer FSM states (IDLE, SHIFT)
//   WIDTH_DEFAULT  : default word width
//   BIT_CNT_W      : bit-counter width for the default word width
//   bit_cnt_width(): bit-counter width for an arbitrary word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 4;
  localparam int BIT_CNT_W     = $clog2(WIDTH_DEFAULT);

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int bit_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// bit_timer
// Loadable DIV_W-bit down-counter used as the bit-period divider.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value to load
//   zero     : count is zero
// The counter stops at zero rather than wrapping, so an all-ones load
// gives exactly 2^DIV_W cycles before zero is seen again after reload.
module bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
// Accepts one WIDTH-bit word via valid/ready and emits it serially,
// LSB- or MSB-first, each bit held div+1 cycles.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   div           : bit period minus one (sampled at accept)
//   in_valid      : upstream word available
//   in_ready      : able to accept (state decode only)
//   in_data       : word to serialize (sampled at accept)
//   in_msb_first  : 1 = MSB first, 0 = LSB first (sampled at accept)
//   ser_out       : serial bit, 0 while idle
//   ser_valid     : ser_out carries a data bit
//   ser_last      : final bit period of the word
//   done          : one-cycle pulse in the first idle cycle after a word
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             done
);

  localparam int BCW = bit_cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               msb_q, msb_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;
  logic               done_q, done_d;

  logic               timer_load;
  logic [DIV_W-1:0]   timer_val;
  logic               timer_zero;

  bit_timer #(
    .DIV_W(DIV_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .zero    (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    msb_d      = msb_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    timer_load = 1'b0;
    timer_val  = div_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = in_data;
          msb_d      = in_msb_first;
          div_d      = div;
          bit_cnt_d  = BCW'(WIDTH - 1);
          timer_load = 1'b1;
          timer_val  = div;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (timer_zero) begin
          if (bit_cnt_q != '0) begin
            shreg_d    = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
            bit_cnt_d  = bit_cnt_q - 1'b1;
            timer_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from next-state values.
    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = ser_valid_d & (msb_d ? shreg_d[WIDTH-1] : shreg_d[0]);
    ser_last_d  = ser_valid_d & (bit_cnt_d == '0);
    done_d      = (state_q == SHIFT) & (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      msb_q       <= 1'b0;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      msb_q       <= msb_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=4, DIV_W=8).
// Expected per-cycle output vectors {in_ready, ser_valid, ser_out,
// ser_last, done} are queued when a word is driven and popped at each
// falling edge.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_msb_first;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic       done;

  int checks = 0;
  int errors = 0;
  string tag;
  logic [4:0] exp_q[$];

  localparam logic [4:0] IDLE_V = 5'b10000;
  localparam logic [4:0] DONE_V = 5'b10001;

  piso_serializer #(
    .WIDTH(4),
    .DIV_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .div         (div),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_msb_first(in_msb_first),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .ser_last    (ser_last),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Expected stream from the word itself: bit k held dv+1 cycles, then done.
  task automatic push_frame(input logic [3:0] d, input int dv, input logic m);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c <= dv; c++) begin
        exp_q.push_back({1'b0, 1'b1, (m ? d[3-k] : d[k]), (k == 3), 1'b0});
      end
    end
    exp_q.push_back(DONE_V);
  endtask

  task automatic start_frame(input logic [3:0] d, input int dv, input logic m);
    in_data      = d;
    div          = 8'(dv);
    in_msb_first = m;
    in_valid     = 1'b1;
    push_frame(d, dv, m);
  endtask

  task automatic check_cycles(input int n, input bit drop_first, input bit perturb);
    logic [4:0] e;
    logic [4:0] obs;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty, got=%b required=entry", tag,
                 {in_ready, ser_valid, ser_out, ser_last, done});
        e = 5'bxxxxx;
      end else begin
        e   = exp_q.pop_front();
        obs = {in_ready, ser_valid, ser_out, ser_last, done};
        assert (obs === e) else begin
          errors++;
          $error("FAIL %s cycle %0d {rdy,vld,out,last,done}: got=%b required=%b",
                 tag, i, obs, e);
        end
      end
      if (i == 0 && drop_first) begin
        in_valid = 1'b0;
      end else if (perturb) begin
        if (e[3] === 1'b1) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = 4'hF;
          div      = 8'd5;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    div          = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_msb_first = 1'b0;
    repeat (2) @(posedge clk);

    tag = "reset";
    exp_q.push_back(IDLE_V);
    check_cycles(1, 0, 0);
    rst = 1'b0;
    exp_q.push_back(IDLE_V);
    check_cycles(1, 0, 0);

    tag = "lsb_div0";
    start_frame(4'b1011, 0, 1'b0);
    exp_q.push_back(IDLE_V);
    check_cycles(6, 1, 0);

    tag = "msb_div0";
    start_frame(4'b1011, 0, 1'b1);
    exp_q.push_back(IDLE_V);
    check_cycles(6, 1, 0);

    tag = "lsb_div2";
    start_frame(4'b0110, 2, 1'b0);
    exp_q.push_back(IDLE_V);
    check_cycles(14, 1, 0);

    // Second word accepted in the done cycle of the first.
    tag = "back_to_back";
    start_frame(4'hA, 0, 1'b0);
    push_frame(4'h5, 0, 1'b0);
    check_cycles(1, 0, 0);
    in_data = 4'h5;
    check_cycles(5, 0, 0);
    in_valid = 1'b0;
    exp_q.push_back(IDLE_V);
    check_cycles(5, 0, 0);

    tag = "busy_ignore";
    start_frame(4'b1001, 1, 1'b1);
    exp_q.push_back(IDLE_V);
    check_cycles(10, 1, 1);
    in_valid = 1'b0;

    tag = "div_max";
    start_frame(4'b0101, 255, 1'b1);
    exp_q.push_back(IDLE_V);
    check_cycles(4 * 256 + 2, 1, 0);

    // Reset lands during the first cycle of bit 2 (div=1).
    tag = "reset_mid";
    start_frame(4'b1011, 1, 1'b0);
    check_cycles(5, 1, 0);
    rst = 1'b1;
    exp_q.delete();
    repeat (4) exp_q.push_back(IDLE_V);
    check_cycles(1, 0, 0);
    rst = 1'b0;
    check_cycles(3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
